alu_seq_ctrl: RTL and testbench

Sequencing controller for the 4-bit ALU lab datapath. It conditions the four raw pushbuttons (synchronize, optional debounce, rising-edge detect) and runs a small state machine that issues one-cycle load enables for operand registers A and B and the output register, plus a register clear. It sits between the board pushbuttons and the `nbit_reg` enables/reset, and is clocked by the divided clock.

---
 rtl/alu_seq_pkg.sv | 27 ++
 rtl/alu_seq_ctrl_btn_cond.sv | 71 +++++++
 rtl/alu_seq_ctrl.sv | 90 +++++++++
 tb/tb_alu_seq_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared state encodings, button indices and strobe bundle for alu_seq_ctrl.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    S_LOAD_A = 2'd0,
    S_LOAD_B = 2'd1,
    S_EXEC   = 2'd2,
    S_SHOW   = 2'd3
  } state_t;

  localparam int PB_LOAD_A = 0;
  localparam int PB_LOAD_B = 1;
  localparam int PB_EXEC   = 2;
  localparam int PB_CLR    = 3;
  localparam int NUM_PB    = 4;

  // One-cycle register-control strobes; at most one bit set per cycle.
  typedef struct packed {
    logic clrRegs;
    logic outEn;
    logic enB;
    logic enA;
  } strobe_t;

endpackage

// File: rtl/alu_seq_ctrl_btn_cond.sv
// btn_cond: conditions one raw pushbutton into a single-cycle press strobe (sync, optional debounce, rise detect).
// Latency: Press is combinational from the conditioned level; 2 edges after Pb without debounce, 2 + DEB_CYCLES with it.
// Backpressure: none; a held button yields exactly one Press, release yields nothing.
// Ports: Clk (divided clock), Rst (sync active-high), Pb (raw async button), Press (rise strobe).
// Config: ALU_SEQ_DEBOUNCE_EN compiles in the debounce counter; otherwise the debounce stage is a wire.
module btn_cond
  import alu_seq_pkg::*;
#(
  parameter int DEB_CYCLES = 1000
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Pb,
  output logic Press
);

  logic sync1;
  logic sync2;
  logic level;
  logic prev;

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= Pb;
      sync2 <= sync1;
    end
  end

`ifdef ALU_SEQ_DEBOUNCE_EN
  localparam int CntW = $clog2(DEB_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEB_CYCLES - 1);

  logic [CntW-1:0] debCnt;
  logic            debLevel;

  // Count consecutive cycles where the synced input disagrees with the
  // debounced level; the level flips on the DEB_CYCLES-th such cycle.
  // The count restarts on any agreeing cycle and never exceeds CntLast.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      debCnt   <= '0;
      debLevel <= 1'b0;
    end else if (sync2 == debLevel) begin
      debCnt   <= '0;
    end else if (debCnt >= CntLast) begin
      debCnt   <= '0;
      debLevel <= sync2;
    end else begin
      debCnt   <= debCnt + 1'b1;
    end
  end

  assign level = debLevel;
`else
  // Debounce disabled: DEB_CYCLES has no effect in this build.
  localparam int UnusedDebCycles = DEB_CYCLES;
  assign level = sync2;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) prev <= 1'b0;
    else     prev <= level;
  end

  assign Press = level & ~prev;

endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: ALU lab sequencer; conditions 4 pushbuttons and issues A/B/output load strobes and register clear.
// Latency: strobe registered 3 edges after a button rises (3 + DEB_CYCLES with ALU_SEQ_DEBOUNCE_EN).
// Backpressure: none; a new press is accepted every cycle, presses invalid for the current state are dropped.
// Ports: Clk, Rst (sync active-high), Pb[3:0] (raw buttons: loadA, loadB, exec, clear),
//        EnA/EnB/OutEn/ClrRegs (one-cycle strobes), State[1:0] (current state for LEDs).
// Config: define ALU_SEQ_DEBOUNCE_EN to add per-button debounce of DEB_CYCLES samples.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int DEB_CYCLES = 1000
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [3:0] Pb,
  output logic       EnA,
  output logic       EnB,
  output logic       OutEn,
  output logic       ClrRegs,
  output logic [1:0] State
);

  logic [NUM_PB-1:0] press;

  for (genvar i = 0; i < NUM_PB; i++) begin : gBtn
    btn_cond #(
      .DEB_CYCLES(DEB_CYCLES)
    ) uBtnCond (
      .Clk  (Clk),
      .Rst  (Rst),
      .Pb   (Pb[i]),
      .Press(press[i])
    );
  end

  state_t  stateQ;
  state_t  stateNext;
  strobe_t strobeQ;
  strobe_t strobeNext;

  // State register; strobes are registered alongside so they align with the new state.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      stateQ  <= S_LOAD_A;
      strobeQ <= '0;
    end else begin
      stateQ  <= stateNext;
      strobeQ <= strobeNext;
    end
  end

  // Next state: clear overrides everything, otherwise only the button that
  // belongs to the current state advances it.
  always_comb begin
    stateNext = stateQ;
    if (press[PB_CLR]) begin
      stateNext = S_LOAD_A;
    end else begin
      case (stateQ)
        S_LOAD_A: if (press[PB_LOAD_A]) stateNext = S_LOAD_B;
        S_LOAD_B: if (press[PB_LOAD_B]) stateNext = S_EXEC;
        S_EXEC:   if (press[PB_EXEC])   stateNext = S_SHOW;
        S_SHOW:   if (press[PB_LOAD_A]) stateNext = S_LOAD_B;
        default:                        stateNext = S_LOAD_A;
      endcase
    end
  end

  // Strobe decode; mutually exclusive by construction.
  always_comb begin
    strobeNext = '0;
    if (press[PB_CLR]) begin
      strobeNext.clrRegs = 1'b1;
    end else begin
      case (stateQ)
        S_LOAD_A: strobeNext.enA   = press[PB_LOAD_A];
        S_LOAD_B: strobeNext.enB   = press[PB_LOAD_B];
        S_EXEC:   strobeNext.outEn = press[PB_EXEC];
        S_SHOW:   strobeNext.enA   = press[PB_LOAD_A];
        default:  strobeNext       = '0;
      endcase
    end
  end

  assign EnA     = strobeQ.enA;
  assign EnB     = strobeQ.enB;
  assign OutEn   = strobeQ.outEn;
  assign ClrRegs = strobeQ.clrRegs;
  assign State   = stateQ;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: randomized and directed bench for alu_seq_ctrl against a behavioural model.
// Latency: model predicts strobes LAT edges after a button rises.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_alu_seq_ctrl;

  localparam int DEB = 8;
`ifdef ALU_SEQ_DEBOUNCE_EN
  localparam int LAT  = 3 + DEB;
  localparam int HOLD = DEB + 4;
`else
  localparam int LAT  = 3;
  localparam int HOLD = 10;
`endif
  localparam int GAP = LAT + 4;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic [3:0] Pb  = 4'b0000;
  logic       EnA, EnB, OutEn, ClrRegs;
  logic [1:0] State;

  alu_seq_ctrl #(.DEB_CYCLES(DEB)) dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .Pb     (Pb),
    .EnA    (EnA),
    .EnB    (EnB),
    .OutEn  (OutEn),
    .ClrRegs(ClrRegs),
    .State  (State)
  );

  always #5 Clk = ~Clk;

  int nChecks = 0;
  int nFails  = 0;
  int cntA = 0, cntB = 0, cntOut = 0, cntClr = 0;

  task automatic check(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Behavioural model: button level after an edge is the raw input seen one
  // edge earlier (zero if reset touched either edge), optionally filtered by a
  // run-length debounce; a press is a level rise, and the state machine follows
  // the transition table directly.
  logic [3:0] mRawPrev = '0, mSyncPrev = '0, mLvl1 = '0, mLvl2 = '0;
  bit         mRstPrev = 1'b0;
  int         mState = 0;
  bit         expA, expB, expOut, expClr;
`ifdef ALU_SEQ_DEBOUNCE_EN
  logic [3:0] mDeb = '0;
  int         mRun[4] = '{0, 0, 0, 0};
`endif

  always @(posedge Clk) begin
    logic [3:0] press, sNew, lvlNew;
    bit r;
    r = Rst;
    press = mLvl1 & ~mLvl2;
    expA = 0; expB = 0; expOut = 0; expClr = 0;
    if (r) mState = 0;
    else if (press[3]) begin expClr = 1; mState = 0; end
    else begin
      case (mState)
        0: if (press[0]) begin expA = 1;   mState = 1; end
        1: if (press[1]) begin expB = 1;   mState = 2; end
        2: if (press[2]) begin expOut = 1; mState = 3; end
        default: if (press[0]) begin expA = 1; mState = 1; end
      endcase
    end
    sNew = (r || mRstPrev) ? 4'b0000 : mRawPrev;
`ifdef ALU_SEQ_DEBOUNCE_EN
    for (int i = 0; i < 4; i++) begin
      if (r) begin mDeb[i] = 1'b0; mRun[i] = 0; end
      else if (mSyncPrev[i] == mDeb[i]) mRun[i] = 0;
      else begin
        mRun[i]++;
        if (mRun[i] >= DEB) begin mDeb[i] = mSyncPrev[i]; mRun[i] = 0; end
      end
    end
    lvlNew = mDeb;
`else
    lvlNew = sNew;
`endif
    mLvl2 = mLvl1; mLvl1 = lvlNew;
    mRawPrev = Pb; mRstPrev = r; mSyncPrev = sNew;

    #2;
    check("EnA", int'(EnA), int'(expA));
    check("EnB", int'(EnB), int'(expB));
    check("OutEn", int'(OutEn), int'(expOut));
    check("ClrRegs", int'(ClrRegs), int'(expClr));
    check("State", int'(State), mState);
    check("onehot", int'($countones({EnA, EnB, OutEn, ClrRegs}) <= 1), 1);
    cntA += int'(EnA); cntB += int'(EnB); cntOut += int'(OutEn); cntClr += int'(ClrRegs);
  end

  task automatic waitEdges(input int n);
    repeat (n) @(posedge Clk);
    #3;
  endtask

  task automatic pressBtn(input logic [3:0] mask);
    @(negedge Clk);
    Pb = mask;
    repeat (HOLD) @(negedge Clk);
    Pb = 4'b0000;
    repeat (GAP) @(negedge Clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int sA, sB, sOut, sClr;
    // Reset
    repeat (3) @(negedge Clk);
    waitEdges(0);
    check("reset State", int'(State), 0);
    check("reset strobes", int'({EnA, EnB, OutEn, ClrRegs}), 0);
    @(negedge Clk);
    Rst = 1'b0;
    repeat (2) @(negedge Clk);

    // Single held press: EnA exactly LAT edges later, for one cycle.
    Pb = 4'b0001;
    waitEdges(LAT - 1);
    check("EnA early", int'(EnA), 0);
    waitEdges(1);
    check("EnA latency", int'(EnA), 1);
    check("State after A", int'(State), 1);
    waitEdges(1);
    check("EnA width", int'(EnA), 0);
    repeat ((HOLD > LAT + 1) ? HOLD - LAT - 1 : 1) @(negedge Clk);
    Pb = 4'b0000;
    repeat (GAP) @(negedge Clk);
    check("held one pulse", cntA, 1);

    // Full sequence with an ignored exec press in S_LOAD_B.
    sOut = cntOut;
    pressBtn(4'b0100);
    check("exec ignored in LOAD_B", int'(State), 1);
    check("no OutEn in LOAD_B", cntOut - sOut, 0);
    pressBtn(4'b0010);
    check("State after B", int'(State), 2);
    pressBtn(4'b0100);
    check("State after exec", int'(State), 3);
    check("one OutEn", cntOut - sOut, 1);
    check("one EnB", cntB, 1);

    // SHOW + loadA goes straight to S_LOAD_B.
    pressBtn(4'b0001);
    check("SHOW to LOAD_B", int'(State), 1);
    pressBtn(4'b0010);
    check("back in EXEC", int'(State), 2);

    // Clear wins over exec.
    sOut = cntOut; sClr = cntClr;
    pressBtn(4'b1100);
    check("clr State", int'(State), 0);
    check("clr pulse", cntClr - sClr, 1);
    check("clr blocks OutEn", cntOut - sOut, 0);

    // Button held through reset is seen after release but ignored in S_LOAD_A.
    pressBtn(4'b0001);
    check("LOAD_B before reset", int'(State), 1);
    sB = cntB;
    @(negedge Clk);
    Pb = 4'b0010;
    @(negedge Clk);
    Rst = 1'b1;
    waitEdges(1);
    check("rst State", int'(State), 0);
    check("rst strobes", int'({EnA, EnB, OutEn, ClrRegs}), 0);
    waitEdges(1);
    check("rst State 2", int'(State), 0);
    check("rst strobes 2", int'({EnA, EnB, OutEn, ClrRegs}), 0);
    @(negedge Clk);
    Rst = 1'b0;
    repeat (HOLD) @(negedge Clk);
    Pb = 4'b0000;
    repeat (GAP) @(negedge Clk);
    check("post-reset press1 ignored", int'(State), 0);
    check("no EnB after reset", cntB - sB, 0);

`ifdef ALU_SEQ_DEBOUNCE_EN
    // Short glitch filtered; long pulse gives one EnA at LAT edges.
    sA = cntA;
    Pb = 4'b0001;
    repeat (5) @(negedge Clk);
    Pb = 4'b0000;
    repeat (GAP) @(negedge Clk);
    check("glitch filtered", cntA - sA, 0);
    Pb = 4'b0001;
    waitEdges(LAT - 1);
    check("deb EnA early", int'(EnA), 0);
    waitEdges(1);
    check("deb EnA latency", int'(EnA), 1);
    repeat (2) @(negedge Clk);
    Pb = 4'b0000;
    repeat (GAP) @(negedge Clk);
    check("deb one pulse", cntA - sA, 1);
`else
    sA = cntA;
`endif

    // Random stimulus against the model.
    repeat (150) begin
      int pick;
      @(negedge Clk);
      Rst = ($urandom_range(0, 30) == 0);
      pick = $urandom_range(0, 5);
      case (pick)
        0: Pb = 4'b0001;
        1: Pb = 4'b0010;
        2: Pb = 4'b0100;
        3: Pb = 4'b1000;
        4: Pb = 4'(($urandom_range(0, 15)));
        default: Pb = 4'b0000;
      endcase
      @(negedge Clk);
      Rst = 1'b0;
      repeat ($urandom_range(0, HOLD)) @(negedge Clk);
      if ($urandom_range(0, 1) == 0) Pb = 4'b0000;
      repeat ($urandom_range(0, 3)) @(negedge Clk);
    end
    Pb = 4'b0000;
    repeat (GAP) @(negedge Clk);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
